// File: rtl/bias_param_loader_if.sv
// bias_param_loader_if: input and output valid/ready beat streams of the parameter loader
interface bias_param_loader_if #(
   parameter int PRECISION_0 = 16,
   parameter int PAR = 1
);
   logic [PAR-1:0][PRECISION_0-1:0] data_in, data_out;
   logic data_in_valid, data_in_ready, data_out_valid, data_out_ready;
   modport master (
      output data_in, data_in_valid, data_out_ready,
      input data_in_ready, data_out, data_out_valid
   );
   modport slave (
      input data_in, data_in_valid, data_out_ready,
      output data_in_ready, data_out, data_out_valid
   );
endinterface

// File: rtl/bias_param_loader.sv
// bias_param_loader: RAM-backed parameter buffer, loaded over a stream and replayed cyclically
module bias_param_loader #(
   parameter int PRECISION_0 = 16,
   parameter int TENSOR_SIZE_DIM_0 = 32,
   parameter int PARALLELISM_DIM_0 = 1,
   parameter int PARALLELISM_DIM_1 = 1
) (
   input logic clk,
   input logic rst,
   input logic reload,
   bias_param_loader_if.slave bus,
   output logic loaded
);
   localparam int PAR = PARALLELISM_DIM_0 * PARALLELISM_DIM_1;
   localparam int DEPTH = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0;
   localparam int AW = $clog2(DEPTH) + 1;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [0:0] LOAD = 1'b0;
   localparam logic [0:0] STREAM = 1'b1;
   typedef logic [PAR-1:0][PRECISION_0-1:0] beat_t;
   logic [0:0] state;
   logic [AW-1:0] wr_ptr, rd_ptr;
   beat_t mem [2**IW];
   beat_t rd_data, tail;
   logic [1:0] occ;
   logic in_flight, in_hs, pop, issue, wr_last, rd_last;
   assign bus.data_in_ready = (state == LOAD) && !reload && !rst;
   assign in_hs = bus.data_in_valid && bus.data_in_ready;
   assign bus.data_out_valid = occ != 2'd0;
   assign pop = bus.data_out_valid && bus.data_out_ready;
   // occupancy + in_flight - pop < 2, rearranged to avoid unsigned underflow
   assign issue = (state == STREAM) && !reload &&
                  (({1'b0, occ} + {2'b0, in_flight}) < (3'd2 + {2'b0, pop}));
   assign wr_last = wr_ptr == AW'(DEPTH - 1);
   assign rd_last = rd_ptr == AW'(DEPTH - 1);
   assign loaded = state == STREAM;
   always_ff @(posedge clk or posedge rst) begin
      if (rst || reload) begin
         state <= LOAD;
         wr_ptr <= '0;
         rd_ptr <= '0;
         in_flight <= 1'b0;
      end else begin
         in_flight <= issue;
         if (in_hs) begin
            wr_ptr <= wr_last ? '0 : wr_ptr + AW'(1);
            if (wr_last) state <= STREAM;
         end
         if (issue) rd_ptr <= rd_last ? '0 : rd_ptr + AW'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (in_hs) mem[wr_ptr[IW-1:0]] <= bus.data_in;
      if (issue) rd_data <= mem[rd_ptr[IW-1:0]];
   end
   // Two-entry output FIFO: data_out is the head, tail holds the second beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst || reload) begin
         occ <= 2'd0;
         bus.data_out <= '0;
         tail <= '0;
      end else begin
         occ <= occ + {1'b0, in_flight} - {1'b0, pop};
         if (in_flight && (occ == 2'd0 || (occ == 2'd1 && pop))) bus.data_out <= rd_data;
         else if (pop) bus.data_out <= tail;
         if (in_flight && ((occ == 2'd1 && !pop) || occ == 2'd2)) tail <= rd_data;
      end
   end
endmodule

// File: tb/tb_bias_param_loader.sv
// tb_bias_param_loader: directed checks of load, cyclic replay, backpressure, reload and reset
module tb_bias_param_loader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic reload0 = 1'b0, reload1 = 1'b0, reload2 = 1'b0;
   logic loaded0, loaded1, loaded2;
   int n_checks = 0, n_fail = 0;
   int k, b;
   logic v, r, hs;
   logic [15:0] d;
   logic [15:0] gaps = 16'b1011_0110_1101_0011;
   logic [3:0][15:0] exp_par;

   always #5 clk = ~clk;

   bias_param_loader_if #(.PRECISION_0(16), .PAR(1)) b0 ();
   bias_param_loader_if #(.PRECISION_0(16), .PAR(4)) b1 ();
   bias_param_loader_if #(.PRECISION_0(16), .PAR(1)) b2 ();

   bias_param_loader u0 (.clk(clk), .rst(rst), .reload(reload0), .bus(b0.slave), .loaded(loaded0));
   bias_param_loader #(.PARALLELISM_DIM_0(4)) u1 (.clk(clk), .rst(rst), .reload(reload1), .bus(b1.slave), .loaded(loaded1));
   bias_param_loader #(.TENSOR_SIZE_DIM_0(1)) u2 (.clk(clk), .rst(rst), .reload(reload2), .bus(b2.slave), .loaded(loaded2));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load0(input logic [15:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         b0.data_in = base + 16'(i);
         b0.data_in_valid = 1'b1;
         tick();
      end
      b0.data_in_valid = 1'b0;
   endtask

   task automatic stream0(input string tag, input logic [15:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         chk(tag, {47'd0, b0.data_out_valid, b0.data_out}, {47'd0, 1'b1, base + 16'(i % 32)});
         tick();
      end
   endtask

   task automatic rst_check(input string tag);
      chk({tag, "_valid"}, 64'(b0.data_out_valid), 64'd0);
      chk({tag, "_data"}, 64'(b0.data_out), 64'd0);
      chk({tag, "_loaded"}, 64'(loaded0), 64'd0);
      chk({tag, "_ready"}, 64'(b0.data_in_ready), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      b0.data_in = '0; b0.data_in_valid = 1'b0; b0.data_out_ready = 1'b0;
      b1.data_in = '0; b1.data_in_valid = 1'b0; b1.data_out_ready = 1'b0;
      b2.data_in = '0; b2.data_in_valid = 1'b0; b2.data_out_ready = 1'b0;
      tick();
      tick();
      rst_check("reset");
      rst = 1'b0;
      #1;
      chk("ready_after_release", 64'(b0.data_in_ready), 64'd1);
      // basic load: 32 back-to-back beats, then exact fill latency
      load0(16'h1000, 32);
      chk("loaded_after_fill", 64'(loaded0), 64'd1);
      chk("ready_after_fill", 64'(b0.data_in_ready), 64'd0);
      chk("valid_e0", 64'(b0.data_out_valid), 64'd0);
      b0.data_out_ready = 1'b1;
      tick();
      chk("valid_e1", 64'(b0.data_out_valid), 64'd0);
      tick();
      stream0("stream_1000", 16'h1000, 40);
      k = 40;
      // random 50% backpressure: head must be the next cyclic value and hold when stalled
      for (int c = 0; c < 200; c++) begin
         v = b0.data_out_valid;
         d = b0.data_out;
         chk("bp_valid", 64'(v), 64'd1);
         if (v) chk("bp_data", 64'(d), 64'(16'h1000 + 16'(k % 32)));
         r = 1'($urandom_range(0, 1));
         b0.data_out_ready = r;
         tick();
         if (v && r) k++;
         else if (v) chk("bp_hold", {47'd0, b0.data_out_valid, b0.data_out}, {47'd0, 1'b1, d});
      end
      // reload with a beat presented in the same cycle
      b0.data_out_ready = 1'b1;
      reload0 = 1'b1;
      b0.data_in = 16'hDEAD;
      b0.data_in_valid = 1'b1;
      #1;
      chk("reload_ready_low", 64'(b0.data_in_ready), 64'd0);
      @(posedge clk);
      #1;
      reload0 = 1'b0;
      chk("reload_valid", 64'(b0.data_out_valid), 64'd0);
      chk("reload_loaded", 64'(loaded0), 64'd0);
      #1;
      chk("reload_ready_back", 64'(b0.data_in_ready), 64'd1);
      load0(16'h2000, 32);
      tick();
      tick();
      stream0("stream_2000", 16'h2000, 34);
      // asynchronous reset mid-stream, then mid-load
      #3;
      rst = 1'b1;
      #1;
      rst_check("arst_stream");
      #1;
      rst = 1'b0;
      #1;
      chk("arst_stream_ready", 64'(b0.data_in_ready), 64'd1);
      load0(16'h3000, 10);
      b0.data_in_valid = 1'b1;
      #3;
      rst = 1'b1;
      #1;
      rst_check("arst_load");
      b0.data_in_valid = 1'b0;
      #1;
      rst = 1'b0;
      tick();
      load0(16'h4000, 32);
      tick();
      tick();
      stream0("stream_4000", 16'h4000, 33);
      // 4 elements per beat, DEPTH 8, with valid gaps
      b1.data_out_ready = 1'b1;
      b = 0;
      for (int c = 0; c < 64 && b < 8; c++) begin
         for (int j = 0; j < 4; j++) b1.data_in[j] = 16'h5000 + 16'(4 * b + j);
         b1.data_in_valid = gaps[c % 16];
         hs = b1.data_in_valid && b1.data_in_ready;
         tick();
         if (hs) b++;
      end
      b1.data_in_valid = 1'b0;
      chk("par_beats_loaded", 64'(b), 64'd8);
      chk("par_loaded", 64'(loaded1), 64'd1);
      for (int c = 0; c < 5 && !b1.data_out_valid; c++) tick();
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < 4; j++) exp_par[j] = 16'h5000 + 16'(4 * (i % 8) + j);
         chk("par_valid", 64'(b1.data_out_valid), 64'd1);
         chk("par_beat", 64'(b1.data_out), 64'(exp_par));
         tick();
      end
      // single-entry vector
      b2.data_in = 16'hABCD;
      b2.data_in_valid = 1'b1;
      tick();
      b2.data_in_valid = 1'b0;
      chk("d1_loaded", 64'(loaded2), 64'd1);
      chk("d1_ready", 64'(b2.data_in_ready), 64'd0);
      b2.data_out_ready = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 6; i++) begin
         chk("d1_stream", {47'd0, b2.data_out_valid, b2.data_out}, {47'd0, 1'b1, 16'hABCD});
         tick();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/bias_param_loader.md
# bias_param_loader

Writable counterpart to the ROM-backed parameter sources: a RAM-backed buffer that accepts a bias or weight vector over a valid/ready input stream, stores it, and then replays it as an endless cyclic valid/ready output stream. It lets the host or DMA side load layer parameters at run time instead of baking them into `$readmemh` images. The output side obeys full backpressure, with no data dropped or duplicated. The input-side register file and read pipeline are internal to the block.

## Interface
- `PRECISION_0`, default 16: element width in bits.
- `TENSOR_SIZE_DIM_0`, default 32: elements in the parameter vector.
- `PARALLELISM_DIM_0`, default 1: elements per beat along dim 0.
- `PARALLELISM_DIM_1`, default 1: elements per beat along dim 1.
- `PAR` (local), `PARALLELISM_DIM_0*PARALLELISM_DIM_1`: elements per beat.
- `DEPTH` (local), `TENSOR_SIZE_DIM_0/PARALLELISM_DIM_0`: beats per vector.
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, asynchronous and active-high.
- `reload`, in, 1: synchronous request to discard the stored vector and re-enter load.
- `data_in`, in, `[PRECISION_0-1:0]` x `PAR`: input beat; element j sits in `data_in[j]`.
- `data_in_valid`, in, 1: input beat valid.
- `data_in_ready`, out, 1: block can accept an input beat.
- `data_out`, out, `[PRECISION_0-1:0]` x `PAR`: output beat; element j sits in `data_out[j]`.
- `data_out_valid`, out, 1: output beat valid.
- `data_out_ready`, in, 1: downstream accepts the beat.
- `loaded`, out, 1: a complete vector is stored and streaming is active.

## Operation
- State machine with two states, LOAD and STREAM.
  - Reset puts it in LOAD.
  - A handshake is a cycle with valid and ready both high.
- LOAD behaviour:
  - `data_in_ready = (state==LOAD) && !reload && !rst`.
  - Each input handshake writes `mem[wr_ptr]` and increments `wr_ptr`. `wr_ptr` is `$clog2(DEPTH)+1` bits wide.
  - The handshake at `wr_ptr==DEPTH-1` moves the state to STREAM and clears `wr_ptr`.
  - Gaps in `data_in_valid` simply stall loading.
- STREAM behaviour:
  - `data_in_ready` is 0.
  - `rd_ptr` walks from 0 to `DEPTH-1`, then wraps to 0, indefinitely. For `DEPTH==1` the same address is read every time.
- Read pipeline:
  - The RAM has a 1-cycle synchronous read.
  - Read data goes into a 2-entry output FIFO. `data_out` is the FIFO head register and `data_out_valid` means the FIFO is not empty.
  - A read is issued in a cycle when `occupancy + in_flight - pop < 2`, where `pop` is an output handshake in that cycle.
  - Each issued read increments `rd_ptr`.
- AXI-stream output rule: while `data_out_valid && !data_out_ready`, `data_out` holds stable and `data_out_valid` stays high.
- `reload` is sampled at the clock edge and overrides everything else. At that edge:
  - the state goes to LOAD;
  - `wr_ptr` and `rd_ptr` clear to 0;
  - the FIFO is flushed;
  - any in-flight read result is discarded;
  - a simultaneous `data_in` beat is not accepted, because ready is low while `reload` is high.
- Stored RAM contents are not cleared by `reload` or `rst`. They are only overwritten by loading.
- `loaded = (state==STREAM)`.

## Timing
- Reset values:
  - state LOAD, all pointers and counts 0;
  - `data_out_valid` 0, `data_out` all zeros, `loaded` 0;
  - `data_in_ready` 0 while `rst` is high, 1 in the first cycle after release.
- Asynchronous `rst` mid-load or mid-stream: all outputs take their reset values immediately, without waiting for a clock edge.
- Fill latency: if the final load handshake completes at edge E:
  - `loaded` is 1 after E;
  - the first read issues in the cycle after E;
  - `data_out_valid` rises after edge E+2 with beat 0.
- Throughput: with `data_out_ready` held at 1, one beat per cycle is sustained, including across the wrap. There are no bubbles.
- Reload mid-stream at edge R: `data_out_valid` is 0 and `loaded` is 0 after R; `data_in_ready` is 1 in the cycle after R if `reload` is low.
- Simultaneous pop and read-return: the FIFO occupancy is unchanged and the head advances.
- The FIFO never overflows; it is guaranteed by the issue rule.

## Test plan
- **Basic load and stream:** defaults; load 32 beats `0x1000+i` with `data_in_valid` held high, then `data_out_ready=1`.
  - `data_out_valid` rises 2 edges after the final load edge.
  - Output is `0x1000..0x101F`, then wraps to `0x1000` with no bubble.
  - `data_in_ready` is 0 after the 32nd beat.
- **Output backpressure:** drive `data_out_ready` with a random 50% pattern for 200 cycles.
  - The consumed sequence is exactly cyclic `0x1000+(k mod 32)`.
  - `data_out` is stable on every stalled cycle.
- **Input gaps and parallelism:** `PARALLELISM_DIM_0=4`, so `DEPTH=8`; insert random `data_in_valid` gaps.
  - All 8 beats are stored in order.
  - `data_out[j]` of beat b equals the loaded element `4b+j`.
- **Mid-stream reload:** assert `reload` for 1 cycle while valid and ready are high, with a `data_in` beat presented in the same cycle; then load `0x2000+i`.
  - The beat presented with `reload` is not accepted.
  - `data_out_valid` drops after that edge.
  - The next stream is `0x2000..0x201F`; no `0x10xx` value appears after the reload.
- **Asynchronous reset:** assert `rst` mid-clock after 10 of 32 load beats.
  - All outputs reach reset values before the next edge.
  - After release, a full 32-beat reload streams correctly starting from index 0.
- **DEPTH==1 case:** `TENSOR_SIZE_DIM_0=1`; load `0xABCD`, then `data_out_ready=1`.
  - `0xABCD` is output every cycle.
  - `loaded=1` after the single load handshake.
